irq_tier_arbiter: RTL and testbench



---
 rtl/irq_tier_arbiter.sv | 145 ++++++++++++++
 tb/tb_irq_tier_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_tier_arbiter.sv
// Clocked tiered interrupt arbiter: captures per-tier/per-channel requests into a
// pending register and offers the highest-priority eligible one over valid/ready.
module irq_tier_arbiter #(
    parameter  int NCH  = 9,
    parameter  int NLVL = 3,
    parameter  int RR   = 0,
    parameter  int EDGE = 0,
    localparam int LW   = (NLVL > 1) ? $clog2(NLVL) : 1,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NLVL*NCH-1:0]  req,
    input  logic [NCH-1:0]       en,
    input  logic                 irq_ready,
    output logic                 irq_valid,
    output logic [LW-1:0]        irq_lvl,
    output logic [CW-1:0]        irq_ch,
    output logic [NLVL*NCH-1:0]  pend,
    output logic [NLVL-1:0]      tier_active
);

    typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NLVL*NCH-1:0]   r_pend;
    logic [NLVL*NCH-1:0]   r_req_q;
    logic [NLVL*NCH-1:0]   w_trig;
    logic [NLVL*NCH-1:0]   w_set;
    logic [NLVL*NCH-1:0]   w_clr;
    logic [NLVL*NCH-1:0]   w_elig;
    logic [CW-1:0]         r_rr_ptr [NLVL];
    logic [CW-1:0]         w_pick   [NLVL];
    logic [NLVL-1:0]       w_hit;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_load;
    logic [LW-1:0]         r_lvl;
    logic [LW-1:0]         w_win_lvl;
    logic [CW-1:0]         r_ch;
    logic [CW-1:0]         w_win_ch;

    // Search order within a tier: plain index, or rotated to start at the RR pointer.
    function automatic int rot_idx(input logic [CW-1:0] ptr, input int k);
        if (RR == 0)
            return k;
        else
            return (int'(ptr) + k) % NCH;
    endfunction

    assign w_trig   = (EDGE != 0) ? (req & ~r_req_q) : req;
    assign w_set    = w_trig & {NLVL{en}};
    assign w_elig   = r_pend & {NLVL{en}};
    assign w_accept = irq_valid & irq_ready;
    assign w_load   = (r_state == S_IDLE) && w_any;

    assign irq_valid = (r_state == S_OFFER);
    assign irq_lvl   = r_lvl;
    assign irq_ch    = r_ch;
    assign pend      = r_pend;

    always_comb begin
        for (int l = 0; l < NLVL; l++)
            tier_active[l] = |w_elig[l*NCH +: NCH];
    end

    always_comb begin
        w_clr = '0;
        if (w_accept) begin
            for (int l = 0; l < NLVL; l++)
                for (int c = 0; c < NCH; c++)
                    if (r_lvl == LW'(l) && r_ch == CW'(c))
                        w_clr[l*NCH + c] = 1'b1;
        end
    end

    always_comb begin
        for (int l = 0; l < NLVL; l++) begin
            w_pick[l] = '0;
            w_hit[l]  = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (!w_hit[l] && w_elig[l*NCH + rot_idx(r_rr_ptr[l], k)]) begin
                    w_hit[l]  = 1'b1;
                    w_pick[l] = CW'(rot_idx(r_rr_ptr[l], k));
                end
            end
        end
    end

    // Descending scan so the lowest-numbered (highest-priority) tier is taken last.
    always_comb begin
        w_any     = 1'b0;
        w_win_lvl = '0;
        w_win_ch  = '0;
        for (int l = NLVL - 1; l >= 0; l--) begin
            if (w_hit[l]) begin
                w_any     = 1'b1;
                w_win_lvl = LW'(l);
                w_win_ch  = w_pick[l];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)     w_state_nxt = S_OFFER;
            S_OFFER: if (irq_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Set takes precedence over the acceptance clear of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_req_q <= '0;
            r_lvl   <= '0;
            r_ch    <= '0;
            for (int l = 0; l < NLVL; l++)
                r_rr_ptr[l] <= '0;
        end else begin
            r_req_q <= req;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_load) begin
                r_lvl <= w_win_lvl;
                r_ch  <= w_win_ch;
            end
            if (RR != 0 && w_accept) begin
                for (int l = 0; l < NLVL; l++)
                    if (r_lvl == LW'(l))
                        r_rr_ptr[l] <= (r_ch == CW'(NCH - 1)) ? '0 : r_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_irq_tier_arbiter.sv
// Directed bench for irq_tier_arbiter: fixed-priority, round-robin and edge-capture
// instances driven through priority, RR, masking, stall, edge and reset scenarios.
module tb_irq_tier_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [26:0] req = '0;
    logic [8:0]  en = 9'h1FF;
    logic        rdy = 1'b0;
    logic [26:0] e_req = '0;
    logic [8:0]  e_en = 9'h1FF;
    logic        e_rdy = 1'b0;

    logic        a_valid, b_valid, e_valid;
    logic [1:0]  a_lvl, b_lvl, e_lvl;
    logic [3:0]  a_ch, b_ch, e_ch;
    logic [26:0] a_pend, b_pend, e_pend;
    logic [2:0]  a_tact, b_tact, e_tact;

    int total = 0;
    int bad   = 0;
    int n_off;
    int exp_rr [6] = '{2, 4, 7, 2, 4, 7};

    always #5 clk = ~clk;

    irq_tier_arbiter #(.NCH(9), .NLVL(3), .RR(0), .EDGE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req), .en(en), .irq_ready(rdy),
        .irq_valid(a_valid), .irq_lvl(a_lvl), .irq_ch(a_ch),
        .pend(a_pend), .tier_active(a_tact)
    );

    irq_tier_arbiter #(.NCH(9), .NLVL(3), .RR(1), .EDGE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .en(en), .irq_ready(rdy),
        .irq_valid(b_valid), .irq_lvl(b_lvl), .irq_ch(b_ch),
        .pend(b_pend), .tier_active(b_tact)
    );

    irq_tier_arbiter #(.NCH(9), .NLVL(3), .RR(0), .EDGE(1)) u_edge (
        .clk(clk), .rst_n(rst_n), .req(e_req), .en(e_en), .irq_ready(e_rdy),
        .irq_valid(e_valid), .irq_lvl(e_lvl), .irq_ch(e_ch),
        .pend(e_pend), .tier_active(e_tact)
    );

    function automatic logic [26:0] pb(input int l, input int c);
        return 27'(1) << (l * 9 + c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req = '0; e_req = '0; rdy = 1'b0; e_rdy = 1'b0; en = 9'h1FF; e_en = 9'h1FF;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state
        tick;
        chk("rst_valid", 64'(a_valid), 64'(0));
        chk("rst_lvl",   64'(a_lvl),   64'(0));
        chk("rst_ch",    64'(a_ch),    64'(0));
        chk("rst_pend",  64'(a_pend),  64'(0));
        chk("rst_tact",  64'(a_tact),  64'(0));
        chk("rst_epend", 64'(e_pend),  64'(0));
        #2;
        rst_n = 1'b1;

        // Priority: three pulsed requests drain in tier/channel order
        tick;
        do_reset;
        req = pb(2, 0) | pb(1, 5) | pb(1, 3);
        rdy = 1'b1;
        tick;
        req = '0;
        chk("pri_pend0",  64'(a_pend),  64'(pb(2, 0) | pb(1, 5) | pb(1, 3)));
        chk("pri_valid0", 64'(a_valid), 64'(0));
        tick;
        chk("pri_v1", 64'(a_valid), 64'(1));
        chk("pri_l1", 64'(a_lvl),   64'(1));
        chk("pri_c1", 64'(a_ch),    64'(3));
        tick;
        chk("pri_gap1", 64'(a_valid), 64'(0));
        chk("pri_pend1", 64'(a_pend), 64'(pb(2, 0) | pb(1, 5)));
        tick;
        chk("pri_v2", 64'(a_valid), 64'(1));
        chk("pri_l2", 64'(a_lvl),   64'(1));
        chk("pri_c2", 64'(a_ch),    64'(5));
        tick;
        chk("pri_gap2", 64'(a_valid), 64'(0));
        tick;
        chk("pri_v3", 64'(a_valid), 64'(1));
        chk("pri_l3", 64'(a_lvl),   64'(2));
        chk("pri_c3", 64'(a_ch),    64'(0));
        tick;
        chk("pri_end_valid", 64'(a_valid), 64'(0));
        chk("pri_end_pend",  64'(a_pend),  64'(0));

        // Round-robin vs fixed priority under three held requests
        do_reset;
        req = pb(0, 2) | pb(0, 4) | pb(0, 7);
        rdy = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("rr_valid", 64'(b_valid), 64'(1));
            chk("rr_lvl",   64'(b_lvl),   64'(0));
            chk("rr_ch",    64'(b_ch),    64'(exp_rr[i]));
            chk("fix_ch",   64'(a_ch),    64'(2));
            tick;
            chk("rr_gap",   64'(b_valid), 64'(0));
        end

        // Masking: disabled channel keeps its pending bit but is not offered
        do_reset;
        req = pb(0, 1);
        rdy = 1'b1;
        tick;
        chk("msk_pend0", 64'(a_pend), 64'(pb(0, 1)));
        req = pb(1, 1);
        en  = 9'h1FD;
        #1;
        chk("msk_tact0", 64'(a_tact), 64'(0));
        tick;
        req = '0;
        chk("msk_valid0", 64'(a_valid), 64'(0));
        chk("msk_pend1",  64'(a_pend),  64'(pb(0, 1)));
        tick;
        tick;
        chk("msk_valid1", 64'(a_valid), 64'(0));
        chk("msk_pend2",  64'(a_pend),  64'(pb(0, 1)));
        en = 9'h1FF;
        #1;
        chk("msk_tact1", 64'(a_tact), 64'(1));
        tick;
        chk("msk_v", 64'(a_valid), 64'(1));
        chk("msk_l", 64'(a_lvl),   64'(0));
        chk("msk_c", 64'(a_ch),    64'(1));
        chk("msk_pend3", 64'(a_pend), 64'(pb(0, 1)));
        tick;
        chk("msk_done_valid", 64'(a_valid), 64'(0));
        chk("msk_done_pend",  64'(a_pend),  64'(0));

        // Stall: offer held stable, no preemption by a later tier-0 request
        do_reset;
        req = pb(1, 6);
        tick;
        req = '0;
        tick;
        req = pb(0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stl_valid", 64'(a_valid), 64'(1));
            chk("stl_lvl",   64'(a_lvl),   64'(1));
            chk("stl_ch",    64'(a_ch),    64'(6));
            tick;
        end
        rdy = 1'b1;
        tick;
        rdy = 1'b0;
        chk("stl_acc_valid", 64'(a_valid), 64'(0));
        chk("stl_acc_pend",  64'(a_pend),  64'(pb(0, 0)));
        tick;
        req = '0;
        chk("stl_nx_valid", 64'(a_valid), 64'(1));
        chk("stl_nx_lvl",   64'(a_lvl),   64'(0));
        chk("stl_nx_ch",    64'(a_ch),    64'(0));

        // Edge capture: a held request offers once; retoggle at acceptance re-pends
        do_reset;
        e_rdy = 1'b1;
        e_req = pb(0, 3);
        n_off = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (e_valid) begin
                n_off++;
                chk("edg_lvl", 64'(e_lvl), 64'(0));
                chk("edg_ch",  64'(e_ch),  64'(3));
            end
        end
        chk("edg_offers", 64'(n_off),  64'(1));
        chk("edg_pend0",  64'(e_pend), 64'(0));
        e_req = '0;
        e_rdy = 1'b0;
        tick;
        e_req = pb(0, 3);
        tick;
        chk("edg_pend1", 64'(e_pend), 64'(pb(0, 3)));
        tick;
        chk("edg_v1", 64'(e_valid), 64'(1));
        e_req = '0;
        tick;
        e_req = pb(0, 3);
        e_rdy = 1'b1;
        tick;
        e_rdy = 1'b0;
        chk("edg_acc_valid", 64'(e_valid), 64'(0));
        chk("edg_acc_pend",  64'(e_pend),  64'(pb(0, 3)));
        tick;
        chk("edg_v2", 64'(e_valid), 64'(1));
        chk("edg_c2", 64'(e_ch),    64'(3));
        e_rdy = 1'b1;
        tick;
        chk("edg_end_pend", 64'(e_pend), 64'(0));

        // Asynchronous reset in the middle of an offer
        do_reset;
        req = pb(2, 4);
        tick;
        req = '0;
        tick;
        chk("rmo_v_pre", 64'(a_valid), 64'(1));
        chk("rmo_l_pre", 64'(a_lvl),   64'(2));
        chk("rmo_c_pre", 64'(a_ch),    64'(4));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmo_valid", 64'(a_valid), 64'(0));
        chk("rmo_pend",  64'(a_pend),  64'(0));
        chk("rmo_lvl",   64'(a_lvl),   64'(0));
        chk("rmo_ch",    64'(a_ch),    64'(0));
        rst_n = 1'b1;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
